prng_lfsr_gen: RTL

Parametrised Galois-LFSR random word generator; the next-generation PRNG core under the TinyTapeout top level. It generalises the fixed-width PRNG with configurable LFSR width, taps, output word width and seed loading. It delivers words over a valid/ready handshake, either on demand or paced by a built-in rate divider from the system clock frequency.

---
 rtl/prng_lfsr_gen.sv | 105 ++++++++++
 1 files changed

// File: rtl/prng_lfsr_gen.sv
// Galois-LFSR word generator; a word is valid OUT_W enabled cycles after entering GEN, on demand or paced by a rate divider.
// Backpressure: the word is held and the LFSR frozen until out_valid & out_ready; a rate tick dropped meanwhile sets sticky overflow.
module prng_lfsr_gen #(
   parameter int               WIDTH   = 16,
   parameter logic [WIDTH-1:0] TAPS    = 'hB400,
   parameter int               OUT_W   = 8,
   parameter int               CLK_HZ  = 10_000_000,
   parameter int               RATE_HZ = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             overflow,
   output logic [WIDTH-1:0] state
);

   localparam bit PER_EN  = (RATE_HZ != 0);
   localparam int DIV_RAW = CLK_HZ / ((RATE_HZ == 0) ? 1 : RATE_HZ);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CW      = (OUT_W > 1) ? $clog2(OUT_W) : 1;

   typedef enum logic [1:0] {IDLE, GEN, HOLD} fsm_t;

   fsm_t             fsm, fsm_nxt, fsm_init;
   logic [WIDTH-1:0] lfsr, lfsr_nxt;
   logic [OUT_W-1:0] sh, sh_nxt, word;
   logic [OUT_W:0]   sh_cat;
   logic [CW-1:0]    cnt;
   logic [DW-1:0]    div_cnt;
   logic             ovf, bit_out, step, last, tick, periodic_sel;

   assign bit_out      = lfsr[0];
   assign lfsr_nxt     = (lfsr >> 1) ^ (bit_out ? TAPS : '0);
   assign sh_cat       = {sh, bit_out};
   assign sh_nxt       = sh_cat[OUT_W-1:0];
   assign step         = (fsm == GEN) && en;
   assign last         = step && (cnt == CW'(OUT_W - 1));
   assign tick         = PER_EN && en && (div_cnt == DW'(DIV - 1));
   // With RATE_HZ == 0 periodic mode collapses onto on-demand behaviour.
   assign periodic_sel = PER_EN && mode;
   assign fsm_init     = periodic_sel ? IDLE : GEN;

   always_comb begin
      fsm_nxt = fsm;
      if (seed_load) begin
         fsm_nxt = fsm_init;
      end else begin
         case (fsm)
            IDLE:    if (tick)      fsm_nxt = GEN;
            GEN:     if (last)      fsm_nxt = HOLD;
            HOLD:    if (out_ready) fsm_nxt = periodic_sel ? IDLE : GEN;
            default:                fsm_nxt = fsm_init;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) fsm <= fsm_init;
      else     fsm <= fsm_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr    <= WIDTH'(1);
         sh      <= '0;
         word    <= '0;
         cnt     <= '0;
         div_cnt <= '0;
         ovf     <= 1'b0;
      end else if (seed_load) begin
         // The all-zero state would lock the LFSR, so it is replaced by 1.
         lfsr    <= (seed == '0) ? WIDTH'(1) : seed;
         sh      <= '0;
         cnt     <= '0;
         div_cnt <= '0;
         ovf     <= 1'b0;
      end else begin
         if (step) begin
            lfsr <= lfsr_nxt;
            sh   <= sh_nxt;
            if (last) begin
               cnt  <= '0;
               word <= sh_nxt;
            end else begin
               cnt  <= cnt + CW'(1);
            end
         end
         if (PER_EN && en) div_cnt <= tick ? '0 : div_cnt + DW'(1);
         if (tick && mode && (fsm != IDLE)) ovf <= 1'b1;
      end
   end

   assign out_valid = (fsm == HOLD);
   assign out_data  = word;
   assign overflow  = ovf;
   assign state     = lfsr;

endmodule
